// File: rtl/mario_pkg.sv
// Shared definitions for the Mario object DMA block: state encoding and
// the default transfer geometry.
package mario_pkg;

   localparam int          XFER_LEN_DEF = 384;
   localparam logic [15:0] SRC_BASE_DEF = 16'h6900;
   localparam int          IDX_W        = 9;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_REQ,
      ST_READ,
      ST_WRITE,
      ST_RELEASE
   } dma_state_t;

endpackage

// File: rtl/mario_obj_dma_if.sv
// CPU bus and object RAM write port seen by the object DMA. Member names keep
// the direction prefix from the DMA's point of view (master side).
interface mario_obj_dma_if;

   logic        O_BUSRQ_N;
   logic        I_BUSAK_N;
   logic [15:0] O_CPU_A;
   logic        O_CPU_RD_N;
   logic [7:0]  I_CPU_D;
   logic [9:0]  O_OBJ_DMA_A;
   logic [7:0]  O_OBJ_DMA_D;
   logic        O_OBJ_DMA_CE;

   modport master (
      output O_BUSRQ_N, O_CPU_A, O_CPU_RD_N, O_OBJ_DMA_A, O_OBJ_DMA_D, O_OBJ_DMA_CE,
      input  I_BUSAK_N, I_CPU_D
   );

   modport slave (
      input  O_BUSRQ_N, O_CPU_A, O_CPU_RD_N, O_OBJ_DMA_A, O_OBJ_DMA_D, O_OBJ_DMA_CE,
      output I_BUSAK_N, I_CPU_D
   );

endinterface

// File: rtl/mario_dma_addr_gen.sv
// Byte index counter for the object DMA plus the CPU source address derived
// from it. The counter stops at the last byte instead of wrapping.
module mario_dma_addr_gen
   import mario_pkg::*;
#(
   parameter int          XFER_LEN = XFER_LEN_DEF,
   parameter logic [15:0] SRC_BASE = SRC_BASE_DEF
) (
   input  logic             CLK_4F,
   input  logic             W_RST_4F,
   input  logic             clear,
   input  logic             incr,
   output logic [IDX_W-1:0] index,
   output logic [15:0]      src_addr,
   output logic             term_cnt
);

   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(XFER_LEN - 1);

   // Index register: cleared at each start, advanced once per written byte.
   always_ff @(posedge CLK_4F or negedge W_RST_4F) begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples the pre-edge values of the others.
      if (!W_RST_4F)
         index <= '0;
      else if (clear)
         index <= '0;
      else if (incr && !term_cnt)
         index <= index + 1'b1;
   end

   assign term_cnt = (index == LAST_IDX);
   assign src_addr = SRC_BASE + {{(16 - IDX_W){1'b0}}, index};

endmodule

// File: rtl/mario_obj_dma.sv
// Object (sprite) DMA: on a start edge, requests the CPU bus, copies XFER_LEN
// bytes from SRC_BASE into object RAM bank I_BANK, then releases the bus.
module mario_obj_dma
   import mario_pkg::*;
#(
   parameter int          XFER_LEN = XFER_LEN_DEF,
   parameter logic [15:0] SRC_BASE = SRC_BASE_DEF
) (
   input  logic           CLK_4F,
   input  logic           W_RST_4F,
   input  logic           I_START,
   input  logic           I_BANK,
   output logic           O_BUSY,
   output logic           O_DONE,
   mario_obj_dma_if.master bus
);

   dma_state_t       state;
   dma_state_t       state_nxt;
   logic             start_q;
   logic             start_armed;
   logic             start_edge;
   logic             bank_q;
   logic             idx_clear;
   logic             idx_incr;
   logic [IDX_W-1:0] index;
   logic [15:0]      src_addr;
   logic             term_cnt;
   logic [9:0]       dma_a;
   logic [7:0]       dma_d;

   // start_armed stays low for the first cycle out of reset so an I_START
   // level that is already high cannot look like a fresh edge.
   assign start_edge = I_START & ~start_q & start_armed;

   mario_dma_addr_gen #(
      .XFER_LEN (XFER_LEN),
      .SRC_BASE (SRC_BASE)
   ) u_addr_gen (
      .CLK_4F   (CLK_4F),
      .W_RST_4F (W_RST_4F),
      .clear    (idx_clear),
      .incr     (idx_incr),
      .index    (index),
      .src_addr (src_addr),
      .term_cnt (term_cnt)
   );

   // State register.
   always_ff @(posedge CLK_4F or negedge W_RST_4F) begin
      if (!W_RST_4F)
         state <= ST_IDLE;
      else
         state <= state_nxt;
   end

   // Next-state logic: a bus grant lost during READ drops back to REQ and
   // retries the same byte.
   always_comb begin
      // NOTE: default every combinational output first so no path infers a latch.
      state_nxt = state;
      unique case (state)
         ST_IDLE:    if (start_edge)     state_nxt = ST_REQ;
         ST_REQ:     if (!bus.I_BUSAK_N) state_nxt = ST_READ;
         ST_READ:    state_nxt = bus.I_BUSAK_N ? ST_REQ : ST_WRITE;
         ST_WRITE:   state_nxt = term_cnt ? ST_RELEASE : ST_READ;
         ST_RELEASE: if (bus.I_BUSAK_N)  state_nxt = ST_IDLE;
         default:    state_nxt = ST_IDLE;
      endcase
   end

   // Output decode: bus strobes are pure functions of state so an async reset
   // forces them inactive immediately.
   always_comb begin
      bus.O_BUSRQ_N    = 1'b1;
      bus.O_CPU_RD_N   = 1'b1;
      bus.O_CPU_A      = SRC_BASE;
      bus.O_OBJ_DMA_CE = 1'b0;
      O_BUSY           = 1'b1;
      O_DONE           = 1'b0;
      idx_clear        = 1'b0;
      idx_incr         = 1'b0;
      unique case (state)
         ST_IDLE: begin
            O_BUSY    = 1'b0;
            idx_clear = start_edge;
         end
         ST_REQ: begin
            bus.O_BUSRQ_N = 1'b0;
         end
         ST_READ: begin
            bus.O_BUSRQ_N  = 1'b0;
            bus.O_CPU_RD_N = 1'b0;
            bus.O_CPU_A    = src_addr;
         end
         ST_WRITE: begin
            bus.O_BUSRQ_N    = 1'b0;
            bus.O_OBJ_DMA_CE = 1'b1;
            idx_incr         = ~term_cnt;
         end
         ST_RELEASE: begin
            O_DONE = bus.I_BUSAK_N;
         end
         default: begin
            O_BUSY = 1'b0;
         end
      endcase
   end

   // Start-edge detector and bank latch; the bank is frozen for the whole
   // transfer.
   always_ff @(posedge CLK_4F or negedge W_RST_4F) begin
      if (!W_RST_4F) begin
         start_q     <= 1'b0;
         start_armed <= 1'b0;
         bank_q      <= 1'b0;
      end else begin
         start_q     <= I_START;
         start_armed <= 1'b1;
         if (state == ST_IDLE && start_edge)
            bank_q <= I_BANK;
      end
   end

   // Write port registers: loaded at the end of a granted READ so they are
   // valid throughout WRITE and hold afterwards.
   always_ff @(posedge CLK_4F or negedge W_RST_4F) begin
      if (!W_RST_4F) begin
         dma_a <= '0;
         dma_d <= '0;
      end else if (state == ST_READ && !bus.I_BUSAK_N) begin
         dma_a <= {bank_q, index};
         dma_d <= bus.I_CPU_D;
      end
   end

   assign bus.O_OBJ_DMA_A = dma_a;
   assign bus.O_OBJ_DMA_D = dma_d;

endmodule

// File: tb/tb_mario_obj_dma.sv
// Self-checking bench for mario_obj_dma: a CPU bus arbiter/memory model, an
// output monitor, and a reference of the expected write sequence.
module tb_mario_obj_dma;

   localparam int          N    = 384;
   localparam logic [15:0] BASE = 16'h6900;

   logic CLK_4F   = 1'b0;
   logic W_RST_4F = 1'b0;
   logic I_START  = 1'b0;
   logic I_BANK   = 1'b0;
   logic O_BUSY;
   logic O_DONE;

   logic start1 = 1'b0;
   logic bank1  = 1'b0;
   logic busy1;
   logic done1;

   mario_obj_dma_if bus ();
   mario_obj_dma_if bus1 ();

   mario_obj_dma dut (
      .CLK_4F   (CLK_4F),
      .W_RST_4F (W_RST_4F),
      .I_START  (I_START),
      .I_BANK   (I_BANK),
      .O_BUSY   (O_BUSY),
      .O_DONE   (O_DONE),
      .bus      (bus.master)
   );

   mario_obj_dma #(.XFER_LEN(1)) dut1 (
      .CLK_4F   (CLK_4F),
      .W_RST_4F (W_RST_4F),
      .I_START  (start1),
      .I_BANK   (bank1),
      .O_BUSY   (busy1),
      .O_DONE   (done1),
      .bus      (bus1.master)
   );

   initial forever #5 CLK_4F = ~CLK_4F;

   // Source memory; read data is garbage whenever the strobe is inactive.
   logic [7:0] mem [0:65535];
   assign bus.I_CPU_D = bus.O_CPU_RD_N ? 8'hEE : mem[bus.O_CPU_A];

   int n_checks = 0;
   int n_pass   = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
   endtask

   // Bus arbiter: grants after grant_delay cycles, can steal the bus for three
   // cycles during the READ of byte steal_idx, releases immediately.
   int grant_delay = 1;
   int steal_idx   = -1;
   initial begin
      int ack_wait   = 0;
      int steal_cnt  = 0;
      int done_steal = -1;
      bus.I_BUSAK_N = 1'b1;
      forever begin
         @(negedge CLK_4F);
         if (steal_cnt > 0) begin
            bus.I_BUSAK_N = 1'b1;
            steal_cnt--;
         end else if (steal_idx >= 0 && steal_idx != done_steal && !bus.O_CPU_RD_N &&
                      bus.O_CPU_A == 16'(BASE + steal_idx)) begin
            bus.I_BUSAK_N = 1'b1;
            steal_cnt     = 2;
            done_steal    = steal_idx;
         end else if (!bus.O_BUSRQ_N) begin
            if (ack_wait > 0) ack_wait--;
            else bus.I_BUSAK_N = 1'b0;
         end else begin
            bus.I_BUSAK_N = 1'b1;
            ack_wait      = grant_delay;
         end
      end
   end

   // Monitor: records every object RAM write and counts events, sampled
   // mid-low-phase away from both clock edges.
   logic [9:0] wr_addr [0:8191];
   logic [7:0] wr_data [0:8191];
   int         wr_cyc  [0:8191];
   int         rd_cnt  [0:65535];
   int n_wr = 0, n_done = 0, n_busy = 0, cyc = 0;
   int n_idle_a_bad = 0, n_ce_bad = 0;
   initial begin
      for (int i = 0; i < 65536; i++) rd_cnt[i] = 0;
      forever begin
         @(negedge CLK_4F);
         #2;
         cyc++;
         if (bus.O_OBJ_DMA_CE && n_wr < 8192) begin
            wr_addr[n_wr] = bus.O_OBJ_DMA_A;
            wr_data[n_wr] = bus.O_OBJ_DMA_D;
            wr_cyc[n_wr]  = cyc;
            n_wr++;
         end
         if (O_DONE) n_done++;
         if (O_BUSY) n_busy++;
         if (!bus.O_CPU_RD_N) rd_cnt[bus.O_CPU_A]++;
         if (bus.O_CPU_RD_N && bus.O_CPU_A !== BASE) n_idle_a_bad++;
         if (bus.O_OBJ_DMA_CE && bus.O_BUSRQ_N) n_ce_bad++;
      end
   end

   task automatic fill_mem();
      for (int i = 0; i < 512; i++) mem[16'(BASE + i)] = 8'($urandom);
   endtask

   task automatic pulse_start();
      @(negedge CLK_4F);
      I_START = 1'b1;
      @(negedge CLK_4F);
      I_START = 1'b0;
   endtask

   task automatic wait_done(input string tag, input int base_done, input int budget);
      int k = 0;
      while (n_done == base_done && k < budget) begin
         @(negedge CLK_4F);
         k++;
      end
      check({tag, "_done_in_time"}, 32'(k < budget), 1);
      repeat (3) @(negedge CLK_4F);
   endtask

   task automatic wait_writes(input int base_wr, input int cnt);
      int k = 0;
      while (n_wr - base_wr < cnt && k < 3000) begin
         @(negedge CLK_4F);
         k++;
      end
   endtask

   // Reference: byte i lands at {bank, i} with the source byte at BASE+i, in order.
   task automatic verify_xfer(input string tag, input int base_wr, input logic bank, input bit chk_rate);
      int bad = 0;
      int first_bad = -1;
      check({tag, "_ce_count"}, n_wr - base_wr, N);
      for (int i = 0; i < N && base_wr + i < n_wr; i++) begin
         logic [9:0] ea;
         logic [7:0] ed;
         ea = {bank, 9'(i)};
         ed = mem[16'(BASE + i)];
         if (wr_addr[base_wr + i] !== ea || wr_data[base_wr + i] !== ed) begin
            bad++;
            if (first_bad < 0) first_bad = i;
         end
      end
      if (first_bad >= 0)
         $display("  %s: first bad byte %0d addr 0x%0h data 0x%0h", tag, first_bad,
                  wr_addr[base_wr + first_bad], wr_data[base_wr + first_bad]);
      check({tag, "_seq_errors"}, bad, 0);
      if (chk_rate && n_wr - base_wr >= N)
         check({tag, "_cycles_first_to_last"}, wr_cyc[base_wr + N - 1] - wr_cyc[base_wr], 2 * (N - 1));
   endtask

   initial begin
      #600000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      int b_wr, b_done, b_busy, b_rd100, b_rd99;
      logic       bk;
      logic [7:0] d1;

      bus1.I_BUSAK_N = 1'b1;
      bus1.I_CPU_D   = 8'h00;

      // Reset state
      #1;
      check("rst_busrq_n", bus.O_BUSRQ_N, 1);
      check("rst_rd_n", bus.O_CPU_RD_N, 1);
      check("rst_ce", bus.O_OBJ_DMA_CE, 0);
      check("rst_busy", O_BUSY, 0);
      check("rst_done", O_DONE, 0);
      check("rst_dma_a", bus.O_OBJ_DMA_A, 0);
      check("rst_dma_d", bus.O_OBJ_DMA_D, 0);
      check("rst_cpu_a", bus.O_CPU_A, BASE);
      repeat (3) @(negedge CLK_4F);
      W_RST_4F = 1'b1;
      repeat (3) @(negedge CLK_4F);

      // Basic transfer, bank 0, grant two cycles after request
      fill_mem();
      grant_delay = 1;
      I_BANK = 1'b0;
      b_wr = n_wr; b_done = n_done;
      pulse_start();
      wait_done("t1", b_done, 3000);
      verify_xfer("t1", b_wr, 1'b0, 1'b1);
      repeat (10) @(negedge CLK_4F);
      check("t1_done_pulses", n_done - b_done, 1);
      check("t1_busy_after", O_BUSY, 0);
      check("t1_dma_a_holds", bus.O_OBJ_DMA_A, 10'h17F);
      check("t1_dma_d_holds", bus.O_OBJ_DMA_D, mem[16'h6A7F]);

      // Bank 1 with I_BANK toggled mid-transfer
      fill_mem();
      grant_delay = int'($urandom_range(0, 3));
      I_BANK = 1'b1;
      b_wr = n_wr; b_done = n_done;
      pulse_start();
      wait_writes(b_wr, 150);
      I_BANK = 1'b0;
      wait_writes(b_wr, 300);
      I_BANK = 1'b1;
      @(negedge CLK_4F);
      I_BANK = 1'b0;
      wait_done("t2", b_done, 3000);
      verify_xfer("t2", b_wr, 1'b1, 1'b1);

      // Bus stolen during byte 100's READ
      fill_mem();
      grant_delay = 1;
      bk = 1'($urandom);
      I_BANK = bk;
      steal_idx = 100;
      b_wr = n_wr; b_done = n_done;
      b_rd100 = rd_cnt[16'(BASE + 100)];
      b_rd99  = rd_cnt[16'(BASE + 99)];
      pulse_start();
      wait_done("t3", b_done, 3000);
      verify_xfer("t3", b_wr, bk, 1'b0);
      check("t3_byte100_reads", rd_cnt[16'(BASE + 100)] - b_rd100, 2);
      check("t3_byte99_reads", rd_cnt[16'(BASE + 99)] - b_rd99, 1);
      check("t3_done_pulses", n_done - b_done, 1);
      steal_idx = -1;

      // Second start edge at byte 50 is ignored
      fill_mem();
      grant_delay = int'($urandom_range(0, 3));
      bk = 1'($urandom);
      I_BANK = bk;
      b_wr = n_wr; b_done = n_done;
      pulse_start();
      wait_writes(b_wr, 50);
      I_START = 1'b1;
      repeat (2) @(negedge CLK_4F);
      I_START = 1'b0;
      wait_done("t4", b_done, 3000);
      repeat (30) @(negedge CLK_4F);
      verify_xfer("t4", b_wr, bk, 1'b0);
      check("t4_done_pulses", n_done - b_done, 1);

      // Reset at byte 200 while I_START is held high
      fill_mem();
      grant_delay = 1;
      b_wr = n_wr; b_done = n_done;
      pulse_start();
      begin
         int k = 0;
         do begin
            @(negedge CLK_4F);
            #3;
            k++;
         end while (!(n_wr - b_wr >= 200 && bus.O_OBJ_DMA_CE) && k < 3000);
      end
      I_START  = 1'b1;
      W_RST_4F = 1'b0;
      #1;
      check("t5_busrq_n_async", bus.O_BUSRQ_N, 1);
      check("t5_ce_async", bus.O_OBJ_DMA_CE, 0);
      check("t5_busy_async", O_BUSY, 0);
      check("t5_rd_n_async", bus.O_CPU_RD_N, 1);
      check("t5_dma_a_async", bus.O_OBJ_DMA_A, 0);
      repeat (4) @(negedge CLK_4F);
      b_wr = n_wr; b_busy = n_busy;
      W_RST_4F = 1'b1;
      repeat (30) @(negedge CLK_4F);
      check("t5_no_done", n_done - b_done, 0);
      check("t5_no_restart_busy", n_busy - b_busy, 0);
      check("t5_no_restart_ce", n_wr - b_wr, 0);
      check("t5_busrq_n_after", bus.O_BUSRQ_N, 1);
      I_START = 1'b0;
      repeat (3) @(negedge CLK_4F);

      // Randomized follow-up transfers after the aborted one
      for (int r = 0; r < 2; r++) begin
         fill_mem();
         grant_delay = int'($urandom_range(0, 4));
         bk = 1'($urandom);
         I_BANK = bk;
         b_wr = n_wr; b_done = n_done;
         pulse_start();
         wait_done("t6", b_done, 3000);
         verify_xfer("t6", b_wr, bk, 1'b1);
      end

      // XFER_LEN = 1 instance, driven cycle by cycle
      @(negedge CLK_4F);
      bank1  = 1'($urandom);
      start1 = 1'b1;
      @(negedge CLK_4F);
      start1 = 1'b0;
      check("t7_busrq_n_req", bus1.O_BUSRQ_N, 0);
      check("t7_busy_req", busy1, 1);
      bus1.I_BUSAK_N = 1'b0;
      @(negedge CLK_4F);
      check("t7_rd_n", bus1.O_CPU_RD_N, 0);
      check("t7_cpu_a", bus1.O_CPU_A, BASE);
      d1 = 8'($urandom);
      bus1.I_CPU_D = d1;
      @(negedge CLK_4F);
      bus1.I_CPU_D = 8'h00;
      check("t7_ce", bus1.O_OBJ_DMA_CE, 1);
      check("t7_dma_a", bus1.O_OBJ_DMA_A, {bank1, 9'd0});
      check("t7_dma_d", bus1.O_OBJ_DMA_D, d1);
      bus1.I_BUSAK_N = 1'b1;
      @(negedge CLK_4F);
      check("t7_ce_off", bus1.O_OBJ_DMA_CE, 0);
      check("t7_busrq_n_rel", bus1.O_BUSRQ_N, 1);
      check("t7_done", done1, 1);
      @(negedge CLK_4F);
      check("t7_idle_busy", busy1, 0);
      check("t7_done_off", done1, 0);

      check("idle_cpu_a_errors", n_idle_a_bad, 0);
      check("ce_without_bus_errors", n_ce_bad, 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
